// File: rtl/if_stage.sv
// RV32 instruction-fetch stage: owns the PC, issues one imem request at a time,
// and feeds the IF/ID register through a 1-entry skid buffer with EX redirect support.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_4,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_SKID  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pc_4;
    logic [31:0] redirect_tgt;
    logic [31:0] skid_instr, skid_instr_nxt;
    logic [31:0] skid_pc_4, skid_pc_4_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] pc_4_nxt;
    logic        valid_nxt;

    assign pc_4         = pc + 32'd4;
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign imem_addr    = pc;
    // req must drop while reset is held, even though the state already reads REQ
    assign imem_req     = rst && (state == S_REQ);

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        skid_instr_nxt = skid_instr;
        skid_pc_4_nxt  = skid_pc_4;
        instr_nxt      = if_id_instr;
        pc_4_nxt       = if_id_pc_4;
        valid_nxt      = if_id_valid;

        // decode consumed the current entry: fall back to a bubble unless refilled below
        if (!id_stall) begin
            instr_nxt = NOP_INSTR;
            valid_nxt = 1'b0;
        end

        if (redirect_valid) begin
            pc_nxt    = redirect_tgt;
            instr_nxt = NOP_INSTR;
            valid_nxt = 1'b0;
            unique case (state)
                S_REQ:   state_nxt = imem_gnt ? S_DRAIN : S_REQ;
                S_WAIT:  state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
                S_SKID:  state_nxt = S_REQ;
                S_DRAIN: state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
                default: state_nxt = S_REQ;
            endcase
        end else begin
            unique case (state)
                S_REQ: begin
                    if (imem_gnt) state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        pc_nxt = pc_4;
                        if (!id_stall || !if_id_valid) begin
                            instr_nxt = imem_rdata;
                            pc_4_nxt  = pc_4;
                            valid_nxt = 1'b1;
                            state_nxt = S_REQ;
                        end else begin
                            skid_instr_nxt = imem_rdata;
                            skid_pc_4_nxt  = pc_4;
                            state_nxt      = S_SKID;
                        end
                    end
                end
                S_SKID: begin
                    if (!id_stall) begin
                        instr_nxt = skid_instr;
                        pc_4_nxt  = skid_pc_4;
                        valid_nxt = 1'b1;
                        state_nxt = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) state_nxt = S_REQ;
                end
                default: state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc_4  <= 32'd0;
            if_id_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            if_id_instr <= instr_nxt;
            if_id_pc_4  <= pc_4_nxt;
            if_id_valid <= valid_nxt;
        end
    end

    // skid payload is qualified by the SKID state, so it carries no reset
    always_ff @(posedge clk) begin
        skid_instr <= skid_instr_nxt;
        skid_pc_4  <= skid_pc_4_nxt;
    end

    a_rvalid_expected: assert property (@(posedge clk) disable iff (!rst)
        imem_rvalid |-> (state == S_WAIT || state == S_DRAIN))
        else $error("imem_rvalid with no request outstanding");

endmodule

// File: tb/tb_if_stage.sv
// Directed-vector bench for if_stage: cycle-by-cycle stimulus with hand-computed
// expectations for fetch, stall/skid, redirect, grant back-pressure, reset and PC wrap.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0050_0093;
    localparam logic [31:0] I1  = 32'h00A0_0113;
    localparam logic [31:0] I2  = 32'h0010_0193;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_4;
    logic        if_id_valid;

    int n_cmp = 0;
    int n_err = 0;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .id_stall      (id_stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc_4    (if_id_pc_4),
        .if_id_valid   (if_id_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic vld);
        check_eq({tag, ".instr"}, if_id_instr, instr);
        check_eq({tag, ".pc_4"},  if_id_pc_4,  pc4);
        check_eq({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, vld});
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check_eq({tag, ".req"},  {31'd0, imem_req}, {31'd0, req});
        check_eq({tag, ".addr"}, imem_addr, addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'd0;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // reset state
        #2 rst = 1'b0;
        #1;
        check_req("rst", 1'b0, 32'h0);
        check_ifid("rst", NOP, 32'h0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        check_req("rel", 1'b1, 32'h0);

        // zero-wait fetch of two words
        imem_gnt = 1'b1;
        tick();
        check_eq("f0.wait_req", {31'd0, imem_req}, 32'd0);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I0;
        tick();
        check_ifid("f0", I0, 32'h4, 1'b1);
        check_req("f1", 1'b1, 32'h4);
        imem_rvalid = 1'b0; imem_gnt = 1'b1;
        tick();
        check_eq("f1.bubble", {31'd0, if_id_valid}, 32'd0);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I1;
        tick();
        check_ifid("f1", I1, 32'h8, 1'b1);
        check_req("f2", 1'b1, 32'h8);
        imem_rvalid = 1'b0;

        // restart from reset for the stall/skid scenario
        rst = 1'b0;
        #1;
        check_ifid("rst2", NOP, 32'h0, 1'b0);
        tick();
        rst = 1'b1;

        id_stall = 1'b1; imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I0;
        tick();
        check_ifid("st0", I0, 32'h4, 1'b1);
        imem_rvalid = 1'b0; imem_gnt = 1'b1;
        tick();
        check_ifid("st1.hold", I0, 32'h4, 1'b1);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I1;
        tick();
        check_ifid("st2.hold", I0, 32'h4, 1'b1);
        check_eq("skid.req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b0;
        tick();
        check_eq("skid.req2", {31'd0, imem_req}, 32'd0);
        tick();
        check_ifid("st3.hold", I0, 32'h4, 1'b1);
        id_stall = 1'b0;
        tick();
        check_ifid("skid.out", I1, 32'h8, 1'b1);
        check_req("skid.next", 1'b1, 32'h8);

        // redirect while waiting: wrong-path word must be drained
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        check_req("drain", 1'b0, 32'h100);
        check_eq("drain.valid", {31'd0, if_id_valid}, 32'd0);
        tick();
        tick();
        check_eq("drain.req2", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check_req("drain.done", 1'b1, 32'h100);
        check_ifid("drain.drop", NOP, 32'h8, 1'b0);
        imem_gnt = 1'b1;
        tick();
        check_eq("rd.wait_valid", {31'd0, if_id_valid}, 32'd0);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I2;
        tick();
        imem_rvalid = 1'b0;
        check_ifid("rd.fetch", I2, 32'h104, 1'b1);

        // redirect coinciding with rvalid under stall: no drain, bubble in IF/ID
        imem_gnt = 1'b1; id_stall = 1'b1;
        tick();
        check_ifid("rv.hold", I2, 32'h104, 1'b1);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        imem_rvalid = 1'b0; redirect_valid = 1'b0; id_stall = 1'b0;
        check_eq("rv.valid", {31'd0, if_id_valid}, 32'd0);
        check_eq("rv.instr", if_id_instr, NOP);
        check_req("rv.next", 1'b1, 32'h200);

        // grant withheld for 5 cycles, redirect on cycle 3
        tick();
        check_req("ng1", 1'b1, 32'h200);
        tick();
        check_req("ng2", 1'b1, 32'h200);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        check_req("ng3", 1'b1, 32'h40);
        tick();
        check_req("ng4", 1'b1, 32'h40);
        tick();
        check_req("ng5", 1'b1, 32'h40);

        // reset during WAIT
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check_eq("rw.wait", {31'd0, imem_req}, 32'd0);
        rst = 1'b0;
        #1;
        check_req("rw.rst", 1'b0, 32'h0);
        check_ifid("rw.rst", NOP, 32'h0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        check_req("rw.rel", 1'b1, 32'h0);
        imem_gnt = 1'b1;
        tick();
        check_eq("rw.valid0", {31'd0, if_id_valid}, 32'd0);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I0;
        tick();
        imem_rvalid = 1'b0;
        check_ifid("rw.fetch", I0, 32'h4, 1'b1);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        check_req("wrap.addr", 1'b1, 32'hFFFF_FFFC);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I1;
        tick();
        imem_rvalid = 1'b0;
        check_ifid("wrap", I1, 32'h0, 1'b1);
        check_req("wrap.next", 1'b1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
